// File: rtl/keypad_entry_ctrl_pkg.sv
// Shared definitions for the keypad entry sequencer: key codes, key classes
// and the controller state encoding.
package keypad_pkg;

   localparam logic [3:0] KEY_ENTER = 4'hA;
   localparam logic [3:0] KEY_BKSP  = 4'hB;
   localparam logic [3:0] KEY_CLR   = 4'hC;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ENTRY = 2'd1,
      HOLD  = 2'd2
   } state_t;

   typedef enum logic [2:0] {
      KC_DIGIT,
      KC_ENTER,
      KC_BKSP,
      KC_CLR,
      KC_INVALID
   } key_class_t;

   function automatic key_class_t classify_key(input logic [3:0] code);
      if (code <= 4'd9) return KC_DIGIT;
      case (code)
         KEY_ENTER: return KC_ENTER;
         KEY_BKSP:  return KC_BKSP;
         KEY_CLR:   return KC_CLR;
         default:   return KC_INVALID;
      endcase
   endfunction

endpackage

// File: rtl/keypad_entry_ctrl_if.sv
// Key input and entry output bundle between scanner, controller and consumer.
// master = environment (scanner + consumer side), slave = the controller.
interface keypad_entry_ctrl_if #(
   parameter int NUM_DIGITS = 4,
   parameter int CNT_W      = 3
);
   logic                    key_valid;
   logic [3:0]              key_code;
   logic                    entry_ready;
   logic                    entry_valid;
   logic [4*NUM_DIGITS-1:0] entry_value;
   logic [CNT_W-1:0]        digit_count;
   logic                    key_reject;
   logic                    timeout;

   modport master (
      output key_valid, key_code, entry_ready,
      input  entry_valid, entry_value, digit_count, key_reject, timeout
   );

   modport slave (
      input  key_valid, key_code, entry_ready,
      output entry_valid, entry_value, digit_count, key_reject, timeout
   );
endinterface

// File: rtl/keypad_entry_ctrl_timer.sv
// Inactivity timer: counts enabled, uncleared cycles and flags the cycle in
// which the count reaches TIMEOUT_CYC-1.
module entry_idle_timer #(
   parameter int TIMEOUT_CYC = 250_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic enable,
   input  logic clear,
   output logic expire
);
   localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   logic [TW-1:0] count;

   // A clear in the expiry cycle suppresses the pulse so a late key wins.
   assign expire = enable && !clear && (count == TW'(TIMEOUT_CYC - 1));

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                        count <= '0;
      else if (clear || !enable || expire) count <= '0;
      else                               count <= count + TW'(1);
   end
endmodule

// File: rtl/keypad_entry_ctrl.sv
// Keypad entry sequencer: assembles BCD digits from scanner key strobes,
// handles edit keys and idle timeout, and offers the entry over valid/ready.
module keypad_entry_ctrl
   import keypad_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int CNT_W       = 3,
   parameter int TIMEOUT_CYC = 250_000_000
) (
   input logic                clk,
   input logic                rst_n,
   keypad_entry_ctrl_if.slave bus
);
   localparam int VW = 4 * NUM_DIGITS;

   state_t           state, state_nxt;
   key_class_t       kclass;
   logic             expire;
   logic [VW-1:0]    value_q, value_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             valid_q, valid_d;
   logic             reject_q, reject_d;
   logic             timeout_q, timeout_d;

   assign kclass = classify_key(bus.key_code);

   entry_idle_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .enable (state == ENTRY),
      .clear  (bus.key_valid),
      .expire (expire)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         value_q   <= '0;
         count_q   <= '0;
         valid_q   <= 1'b0;
         reject_q  <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state     <= state_nxt;
         value_q   <= value_d;
         count_q   <= count_d;
         valid_q   <= valid_d;
         reject_q  <= reject_d;
         timeout_q <= timeout_d;
      end
   end

   // NOTE: every combinational output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (bus.key_valid && kclass == KC_DIGIT) state_nxt = ENTRY;
         ENTRY: begin
            if (bus.key_valid) begin
               case (kclass)
                  KC_ENTER: state_nxt = HOLD;
                  KC_CLR:   state_nxt = IDLE;
                  KC_BKSP:  if (count_q == CNT_W'(1)) state_nxt = IDLE;
                  default:  state_nxt = ENTRY;
               endcase
            end else if (expire) begin
               state_nxt = IDLE;
            end
         end
         HOLD: if (valid_q && bus.entry_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      value_d   = value_q;
      count_d   = count_q;
      reject_d  = 1'b0;
      timeout_d = 1'b0;
      case (state)
         IDLE: begin
            if (bus.key_valid) begin
               if (kclass == KC_DIGIT) begin
                  value_d = (value_q << 4) | VW'(bus.key_code);
                  count_d = CNT_W'(1);
               end else if (kclass == KC_INVALID) begin
                  reject_d = 1'b1;
               end
            end
         end
         ENTRY: begin
            if (bus.key_valid) begin
               case (kclass)
                  KC_DIGIT: begin
                     if (count_q < CNT_W'(NUM_DIGITS)) begin
                        value_d = (value_q << 4) | VW'(bus.key_code);
                        count_d = count_q + CNT_W'(1);
                     end else begin
                        reject_d = 1'b1;
                     end
                  end
                  KC_BKSP: begin
                     value_d = value_q >> 4;
                     count_d = count_q - CNT_W'(1);
                  end
                  KC_CLR: begin
                     value_d = '0;
                     count_d = '0;
                  end
                  KC_INVALID: reject_d = 1'b1;
                  default: ;
               endcase
            end else if (expire) begin
               value_d   = '0;
               count_d   = '0;
               timeout_d = 1'b1;
            end
         end
         HOLD: begin
            reject_d = bus.key_valid;
            if (valid_q && bus.entry_ready) begin
               value_d = '0;
               count_d = '0;
            end
         end
         default: begin
            value_d = '0;
            count_d = '0;
         end
      endcase
      valid_d = (state_nxt == HOLD);
   end

   assign bus.entry_valid = valid_q;
   assign bus.entry_value = value_q;
   assign bus.digit_count = count_q;
   assign bus.key_reject  = reject_q;
   assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Directed bench for keypad_entry_ctrl with NUM_DIGITS=4 and TIMEOUT_CYC=100.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_keypad_entry_ctrl;
   import keypad_pkg::*;

   localparam int NUM_DIGITS  = 4;
   localparam int CNT_W       = 3;
   localparam int TIMEOUT_CYC = 100;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   keypad_entry_ctrl_if #(.NUM_DIGITS(NUM_DIGITS), .CNT_W(CNT_W)) bus ();

   keypad_entry_ctrl #(
      .NUM_DIGITS (NUM_DIGITS),
      .CNT_W      (CNT_W),
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   task automatic press(input logic [3:0] code);
      @(negedge clk);
      bus.key_valid = 1'b1;
      bus.key_code  = code;
      @(negedge clk);
      bus.key_valid = 1'b0;
      bus.key_code  = 4'h0;
   endtask

   task automatic test_reset();
      rst_n           = 1'b0;
      bus.key_valid   = 1'b0;
      bus.key_code    = 4'h0;
      bus.entry_ready = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({bus.entry_valid, bus.key_reject, bus.timeout} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_flags: got %b expected 000", {bus.entry_valid, bus.key_reject, bus.timeout});
      end
      n_checks++;
      if (bus.entry_value !== 16'h0 || bus.digit_count !== 3'd0) begin
         n_fail++;
         $display("FAIL reset_data: got value=%h count=%0d expected 0000/0", bus.entry_value, bus.digit_count);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_entry_handshake();
      press(4'h1); press(4'h2); press(4'h3);
      n_checks++;
      if (bus.entry_value !== 16'h0123 || bus.digit_count !== 3'd3) begin
         n_fail++;
         $display("FAIL partial_123: got value=%h count=%0d expected 0123/3", bus.entry_value, bus.digit_count);
      end
      press(4'h4);
      n_checks++;
      if (bus.entry_value !== 16'h1234 || bus.digit_count !== 3'd4) begin
         n_fail++;
         $display("FAIL full_1234: got value=%h count=%0d expected 1234/4", bus.entry_value, bus.digit_count);
      end
      n_checks++;
      if (bus.entry_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL valid_before_enter: got %b expected 0", bus.entry_valid);
      end
      press(KEY_ENTER);
      repeat (3) @(negedge clk);
      n_checks++;
      if (bus.entry_valid !== 1'b1 || bus.entry_value !== 16'h1234 || bus.digit_count !== 3'd4) begin
         n_fail++;
         $display("FAIL hold_1234: got valid=%b value=%h count=%0d expected 1/1234/4",
                  bus.entry_valid, bus.entry_value, bus.digit_count);
      end
      bus.entry_ready = 1'b1;
      @(negedge clk);
      bus.entry_ready = 1'b0;
      n_checks++;
      if (bus.entry_valid !== 1'b0 || bus.entry_value !== 16'h0 || bus.digit_count !== 3'd0) begin
         n_fail++;
         $display("FAIL accept_clear: got valid=%b value=%h count=%0d expected 0/0000/0",
                  bus.entry_valid, bus.entry_value, bus.digit_count);
      end
   endtask

   task automatic test_overflow_backspace();
      press(4'h5); press(4'h6); press(4'h7); press(4'h8); press(4'h9);
      n_checks++;
      if (bus.key_reject !== 1'b1 || bus.entry_value !== 16'h5678 || bus.digit_count !== 3'd4) begin
         n_fail++;
         $display("FAIL overflow_reject: got rej=%b value=%h count=%0d expected 1/5678/4",
                  bus.key_reject, bus.entry_value, bus.digit_count);
      end
      @(negedge clk);
      n_checks++;
      if (bus.key_reject !== 1'b0) begin
         n_fail++;
         $display("FAIL reject_one_cycle: got %b expected 0", bus.key_reject);
      end
      press(KEY_BKSP);
      n_checks++;
      if (bus.entry_value !== 16'h0567 || bus.digit_count !== 3'd3) begin
         n_fail++;
         $display("FAIL bksp_1: got value=%h count=%0d expected 0567/3", bus.entry_value, bus.digit_count);
      end
      press(KEY_BKSP);
      n_checks++;
      if (bus.entry_value !== 16'h0056 || bus.digit_count !== 3'd2) begin
         n_fail++;
         $display("FAIL bksp_2: got value=%h count=%0d expected 0056/2", bus.entry_value, bus.digit_count);
      end
      press(KEY_BKSP); press(KEY_BKSP);
      n_checks++;
      if (bus.entry_value !== 16'h0 || bus.digit_count !== 3'd0) begin
         n_fail++;
         $display("FAIL bksp_to_empty: got value=%h count=%0d expected 0000/0", bus.entry_value, bus.digit_count);
      end
      press(KEY_ENTER);
      n_checks++;
      if (bus.entry_valid !== 1'b0 || bus.key_reject !== 1'b0) begin
         n_fail++;
         $display("FAIL empty_after_bksp_enter: got valid=%b rej=%b expected 0/0", bus.entry_valid, bus.key_reject);
      end
   endtask

   task automatic test_clear_and_idle_keys();
      press(4'h7);
      press(KEY_CLR);
      n_checks++;
      if (bus.entry_value !== 16'h0 || bus.digit_count !== 3'd0 || bus.key_reject !== 1'b0) begin
         n_fail++;
         $display("FAIL clear: got value=%h count=%0d rej=%b expected 0000/0/0",
                  bus.entry_value, bus.digit_count, bus.key_reject);
      end
      press(KEY_ENTER);
      n_checks++;
      if (bus.entry_valid !== 1'b0 || bus.key_reject !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_enter: got valid=%b rej=%b expected 0/0", bus.entry_valid, bus.key_reject);
      end
      press(4'hE);
      n_checks++;
      if (bus.key_reject !== 1'b1 || bus.digit_count !== 3'd0) begin
         n_fail++;
         $display("FAIL idle_invalid: got rej=%b count=%0d expected 1/0", bus.key_reject, bus.digit_count);
      end
      press(4'h1); press(4'hD);
      n_checks++;
      if (bus.key_reject !== 1'b1 || bus.entry_value !== 16'h0001) begin
         n_fail++;
         $display("FAIL entry_invalid: got rej=%b value=%h expected 1/0001", bus.key_reject, bus.entry_value);
      end
      press(KEY_CLR);
   endtask

   task automatic test_timeout();
      int pulses = 0;
      int at     = -1;
      press(4'h3);
      for (int i = 1; i <= 120; i++) begin
         @(negedge clk);
         if (bus.timeout === 1'b1) begin
            pulses++;
            at = i;
         end
      end
      n_checks++;
      if (pulses !== 1 || at !== TIMEOUT_CYC) begin
         n_fail++;
         $display("FAIL timeout_pulse: got %0d pulses at cycle %0d expected 1 at %0d", pulses, at, TIMEOUT_CYC);
      end
      n_checks++;
      if (bus.entry_value !== 16'h0 || bus.digit_count !== 3'd0) begin
         n_fail++;
         $display("FAIL timeout_discard: got value=%h count=%0d expected 0000/0", bus.entry_value, bus.digit_count);
      end
   endtask

   task automatic test_timeout_race();
      int pulses = 0;
      int at     = -1;
      press(4'h3);
      // Strobe key 2 exactly in the cycle the timer would expire.
      repeat (TIMEOUT_CYC - 1) @(negedge clk);
      bus.key_valid = 1'b1;
      bus.key_code  = 4'h2;
      @(negedge clk);
      bus.key_valid = 1'b0;
      n_checks++;
      if (bus.timeout !== 1'b0 || bus.entry_value !== 16'h0032 || bus.digit_count !== 3'd2) begin
         n_fail++;
         $display("FAIL key_beats_timer: got to=%b value=%h count=%0d expected 0/0032/2",
                  bus.timeout, bus.entry_value, bus.digit_count);
      end
      for (int i = 1; i <= 120; i++) begin
         @(negedge clk);
         if (bus.timeout === 1'b1) begin
            pulses++;
            at = i;
         end
      end
      n_checks++;
      if (pulses !== 1 || at !== TIMEOUT_CYC) begin
         n_fail++;
         $display("FAIL timer_restart: got %0d pulses at cycle %0d expected 1 at %0d", pulses, at, TIMEOUT_CYC);
      end
   endtask

   task automatic test_hold_collision();
      int stuck = 0;
      press(4'h9);
      press(KEY_ENTER);
      repeat (TIMEOUT_CYC + 10) begin
         @(negedge clk);
         if (bus.timeout !== 1'b0 || bus.entry_valid !== 1'b1) stuck++;
      end
      n_checks++;
      if (stuck !== 0) begin
         n_fail++;
         $display("FAIL hold_no_timeout: got %0d bad cycles expected 0", stuck);
      end
      press(4'h5);
      n_checks++;
      if (bus.key_reject !== 1'b1 || bus.entry_valid !== 1'b1 || bus.entry_value !== 16'h0009) begin
         n_fail++;
         $display("FAIL hold_key_drop: got rej=%b valid=%b value=%h expected 1/1/0009",
                  bus.key_reject, bus.entry_valid, bus.entry_value);
      end
      @(negedge clk);
      bus.key_valid   = 1'b1;
      bus.key_code    = 4'h4;
      bus.entry_ready = 1'b1;
      n_checks++;
      if (bus.entry_value !== 16'h0009 || bus.entry_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL accepted_value: got valid=%b value=%h expected 1/0009", bus.entry_valid, bus.entry_value);
      end
      @(negedge clk);
      bus.key_valid   = 1'b0;
      bus.entry_ready = 1'b0;
      n_checks++;
      if (bus.key_reject !== 1'b1 || bus.entry_valid !== 1'b0 || bus.entry_value !== 16'h0 || bus.digit_count !== 3'd0) begin
         n_fail++;
         $display("FAIL collision_result: got rej=%b valid=%b value=%h count=%0d expected 1/0/0000/0",
                  bus.key_reject, bus.entry_valid, bus.entry_value, bus.digit_count);
      end
      press(4'h6);
      n_checks++;
      if (bus.entry_value !== 16'h0006 || bus.digit_count !== 3'd1) begin
         n_fail++;
         $display("FAIL idle_after_hold: got value=%h count=%0d expected 0006/1", bus.entry_value, bus.digit_count);
      end
      press(KEY_CLR);
   endtask

   task automatic test_reset_mid_entry();
      press(4'h1); press(4'h2);
      n_checks++;
      if (bus.entry_value !== 16'h0012) begin
         n_fail++;
         $display("FAIL pre_reset_value: got %h expected 0012", bus.entry_value);
      end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (bus.entry_value !== 16'h0 || bus.digit_count !== 3'd0 || bus.entry_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset: got value=%h count=%0d valid=%b expected 0000/0/0",
                  bus.entry_value, bus.digit_count, bus.entry_valid);
      end
      @(negedge clk);
      rst_n = 1'b1;
      press(4'h8);
      n_checks++;
      if (bus.entry_value !== 16'h0008 || bus.digit_count !== 3'd1) begin
         n_fail++;
         $display("FAIL post_reset_key: got value=%h count=%0d expected 0008/1", bus.entry_value, bus.digit_count);
      end
   endtask

   initial begin
      test_reset();
      test_entry_handshake();
      test_overflow_backspace();
      test_clear_and_idle_keys();
      test_timeout();
      test_timeout_race();
      test_hold_collision();
      test_reset_mid_entry();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/keypad_entry_ctrl.md
Name: keypad_entry_ctrl

Overview:
Sequencer that sits downstream of the 4x4 keypad scanner. It consumes the scanner's one-cycle key strobe and 4-bit key code, and assembles up to NUM_DIGITS decimal digits into a packed BCD entry. It handles the edit keys (enter, backspace, clear) and an inactivity timeout. It hands each completed entry to a consumer over a valid/ready handshake, for example a lock comparator or a seven-segment display driver.

Parameters:
NUM_DIGITS, 4, maximum digits held in the entry buffer (1..8)
CNT_W, 3, width of digit_count; must hold NUM_DIGITS (ceil(log2(NUM_DIGITS+1)))
TIMEOUT_CYC, 250_000_000, idle clock cycles before a partial entry is discarded (5 s at 50 MHz)

Ports:
clk  input  1  system clock, 50 MHz
rst_n  input  1  asynchronous active-low reset
key_valid  input  1  one-cycle strobe from the scanner: key_code is valid this cycle
key_code  input  4  scanner key code, 0x0..0xF
entry_ready  input  1  consumer accepts the entry on a cycle where entry_valid and entry_ready are both high
entry_valid  output  1  completed entry available; held until accepted
entry_value  output  4*NUM_DIGITS  packed BCD, most recent digit in [3:0]
digit_count  output  CNT_W  number of digits currently held
key_reject  output  1  one-cycle pulse: key ignored (buffer full, invalid key, or key while HOLD)
timeout  output  1  one-cycle pulse: partial entry discarded by the idle timer

Behaviour:
- Reset (async, rst_n=0): state=IDLE; entry_valid=0, entry_value=0, digit_count=0, key_reject=0, timeout=0; idle counter=0. Reset mid-entry or mid-HOLD discards everything.
- Key classes: 0x0-0x9 = digit; 0xA = ENTER; 0xB = BACKSPACE; 0xC = CLEAR; 0xD-0xF = invalid.
- All outputs are registered. A key strobe in cycle n is reflected in entry_value, digit_count and key_reject at cycle n+1.
- State IDLE (digit_count=0):
  - digit -> entry_value={entry_value[4*NUM_DIGITS-5:0],code}, count=1, go to ENTRY.
  - ENTER, BACKSPACE, CLEAR -> no change, no reject pulse.
  - invalid -> key_reject pulse.
  - Idle timer inactive.
- State ENTRY (digit_count>=1):
  - digit with count<NUM_DIGITS -> shift in at the low nibble, count+1.
  - digit with count==NUM_DIGITS -> key_reject pulse; value unchanged.
  - BACKSPACE -> entry_value>>4 (zero fill at the top), count-1; go to IDLE if count reaches 0.
  - CLEAR -> value=0, count=0, go to IDLE.
  - ENTER -> entry_valid=1 from the next cycle, go to HOLD.
  - invalid -> key_reject pulse.
- Idle timer (ENTRY only):
  - Cleared on every key_valid, including rejected keys.
  - Otherwise increments each cycle.
  - On reaching TIMEOUT_CYC-1: next cycle value=0, count=0, timeout pulse, go to IDLE.
  - If key_valid arrives in the same cycle the timer expires, the key wins and the timer clears.
- State HOLD:
  - entry_valid=1; entry_value and digit_count are frozen.
  - Any key_valid -> key_reject pulse; the key is dropped, including when it coincides with the handshake.
  - Cycle with entry_valid && entry_ready -> next cycle entry_valid=0, value=0, count=0, go to IDLE.
  - entry_ready while not valid has no effect.
  - No timeout in HOLD.
- key_reject and timeout never assert in the same cycle.
- Unused state encodings return to IDLE.

Decomposition:
- Shared package keypad_pkg holds:
  - key code constants KEY_ENTER=4'hA, KEY_BKSP=4'hB, KEY_CLR=4'hC;
  - state encoding IDLE=2'd0, ENTRY=2'd1, HOLD=2'd2.
- One sub-module, entry_idle_timer: clear/enable inputs, an expiry pulse output, parameter TIMEOUT_CYC.

Test Plan:
- Keys 1,2,3,4 then ENTER with entry_ready=0 -> digit_count=4, entry_value=0x1234, entry_valid=1 held; entry_ready=1 for one cycle -> next cycle entry_valid=0, value=0, count=0.
- NUM_DIGITS=4: keys 5,6,7,8,9 -> 9 gives key_reject pulse, value stays 0x5678; then BACKSPACE twice -> value=0x0056, count=2.
- Keys 7, CLEAR -> value=0, count=0, state IDLE; then ENTER -> no entry_valid, no key_reject.
- TIMEOUT_CYC=100: key 3, then no keys for 100 cycles -> timeout pulse once, count=0. Repeat with a key 2 on cycle 99 -> no timeout, value=0x0032.
- HOLD with entry 0x0009: key 4 strobed in the same cycle as entry_ready=1 -> key_reject pulse, accepted value=0x0009, next state IDLE with count=0.
- Reset asserted mid-ENTRY (value 0x0012) -> all outputs 0 immediately; after release, key 8 gives value=0x0008, count=1.
